pushbutton_port: RTL and testbench

Parametrised input port for the Nibbler `uP` that replaces the raw `PUSHBUTTONS` bus feeding the IN path. Per channel it:
- synchronises the asynchronous switch input to `clk`;
- debounces it with a consecutive-sample counter;
- detects the press (rising) edge;
- in sticky mode, holds each press until the core reads the port.

The block sits between the board buttons and the data-bus mux that services the IN instruction.

---
 rtl/pushbutton_port.sv | 75 +++++++
 tb/tb_pushbutton_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_port.sv
// Button input port for the IN path: per-channel two-flop synchroniser,
// consecutive-sample debounce, press-edge detect and read-cleared press latch.
module pushbutton_port #(
   parameter int unsigned N_BUTTONS       = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter bit          STICKY          = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] buttons_raw,
   input  logic                 rd_en,
   output logic [N_BUTTONS-1:0] data_out,
   output logic [N_BUTTONS-1:0] level,
   output logic [N_BUTTONS-1:0] press_pulse,
   output logic                 any_pending
);

   localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_BUTTONS-1:0] s1;
   logic [N_BUTTONS-1:0] s2;
   logic [N_BUTTONS-1:0] stb;
   logic [N_BUTTONS-1:0] stb_nxt;
   logic [N_BUTTONS-1:0] lat;
   logic [N_BUTTONS-1:0] accept;
   logic [CW-1:0]        cnt     [N_BUTTONS];
   logic [CW-1:0]        cnt_nxt [N_BUTTONS];

   // Any sample agreeing with the stable level restarts the count, so only
   // DEBOUNCE_CYCLES consecutive differing samples move the level.
   always_comb begin
      stb_nxt = stb;
      accept  = '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != stb[i]) begin
            if (cnt[i] == CNT_MAX) begin
               stb_nxt[i] = s2[i];
               accept[i]  = s2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1          <= '0;
         s2          <= '0;
         stb         <= '0;
         lat         <= '0;
         press_pulse <= '0;
         for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1          <= buttons_raw;
         s2          <= s1;
         stb         <= stb_nxt;
         press_pulse <= accept;
         // A press accepted on the read edge survives the clear.
         lat         <= accept | (rd_en ? '0 : lat);
         for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign level       = stb;
   assign data_out    = STICKY ? lat : stb;
   assign any_pending = |lat;

endmodule

// File: tb/tb_pushbutton_port.sv
// Directed bench for pushbutton_port: vector table for press/bounce timing,
// hand-written sequences for reset, read clear, collision and level mode.
module tb_pushbutton_port;

   logic       clk;
   logic       reset;
   logic [3:0] raw;
   logic       rd;
   logic [3:0] data_out, level, press_pulse;
   logic       any_pending;

   logic [3:0] raw_l;
   logic       rd_l;
   logic [3:0] data_l, level_l, pulse_l;
   logic       pend_l;

   logic [0:0] raw_d1;
   logic       rd_d1;
   logic [0:0] data_d1, level_d1, pulse_d1;
   logic       pend_d1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   pushbutton_port #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(4), .STICKY(1'b1)) dut (
      .clk(clk), .reset(reset), .buttons_raw(raw), .rd_en(rd),
      .data_out(data_out), .level(level), .press_pulse(press_pulse),
      .any_pending(any_pending)
   );

   pushbutton_port #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(4), .STICKY(1'b0)) dut_l (
      .clk(clk), .reset(reset), .buttons_raw(raw_l), .rd_en(rd_l),
      .data_out(data_l), .level(level_l), .press_pulse(pulse_l),
      .any_pending(pend_l)
   );

   pushbutton_port #(.N_BUTTONS(1), .DEBOUNCE_CYCLES(1), .STICKY(1'b1)) dut_d1 (
      .clk(clk), .reset(reset), .buttons_raw(raw_d1), .rd_en(rd_d1),
      .data_out(data_d1), .level(level_d1), .press_pulse(pulse_d1),
      .any_pending(pend_d1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] raw;
      logic       rd;
      logic [3:0] data;
      logic [3:0] lvl;
      logic [3:0] pulse;
      logic       pend;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [3:0] r, input logic rdv, input logic [3:0] d,
                               input logic [3:0] l, input logic [3:0] p, input logic pe);
      vec_t v;
      v.raw = r; v.rd = rdv; v.data = d; v.lvl = l; v.pulse = p; v.pend = pe;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input string tag, input logic [3:0] d, input logic [3:0] l,
                           input logic [3:0] p, input logic pe);
      chk({tag, " data_out"}, 32'(data_out), 32'(d));
      chk({tag, " level"}, 32'(level), 32'(l));
      chk({tag, " press_pulse"}, 32'(press_pulse), 32'(p));
      chk({tag, " any_pending"}, 32'(any_pending), 32'(pe));
   endtask

   initial begin
      logic [7:0] bpat;
      bpat = 8'b0111_0111;

      // clean press on bit 0, then release
      for (int i = 0; i < 5; i++) add(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1);
      for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      for (int i = 0; i < 3; i++) add(4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      // bounce 1,1,1,0,1,1,1,0 on bit 1, then hold
      for (int i = 0; i < 8; i++)
         add({2'b00, bpat[i], 1'b0}, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      for (int i = 0; i < 5; i++) add(4'b0010, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      add(4'b0010, 1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1);
      add(4'b0010, 1'b0, 4'b0011, 4'b0010, 4'b0000, 1'b1);

      reset = 1'b1; raw = '0; rd = 1'b0;
      raw_l = '0; rd_l = 1'b0; raw_d1 = '0; rd_d1 = 1'b0;
      #2 reset = 1'b0;
      #1 chk_main("por", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      repeat (3) tick();
      reset = 1'b1;

      // reset asserted mid-cycle with all buttons accepted
      raw = 4'b1111;
      repeat (7) tick();
      chk_main("pre_rst", 4'b1111, 4'b1111, 4'b0000, 1'b1);
      #3 reset = 1'b0;
      #1 chk_main("async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk_main("in_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      reset = 1'b1;
      repeat (5) tick();
      chk_main("rel_rst+5", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk_main("rel_rst+6", 4'b1111, 4'b1111, 4'b1111, 1'b1);
      tick();
      chk_main("rel_rst+7", 4'b1111, 4'b1111, 4'b0000, 1'b1);

      raw = 4'b0000; rd = 1'b1;
      tick();
      rd = 1'b0;
      repeat (7) tick();
      chk_main("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      foreach (vecs[i]) begin
         raw = vecs[i].raw;
         rd  = vecs[i].rd;
         tick();
         chk_main($sformatf("vec%0d", i), vecs[i].data, vecs[i].lvl, vecs[i].pulse, vecs[i].pend);
      end
      rd = 1'b0;

      // read clear: lat 0101 seen in the rd_en cycle, 0 after
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("rd_clear0 data_out", 32'(data_out), 32'h0);
      raw = 4'b0111;
      repeat (6) tick();
      chk_main("press02", 4'b0101, 4'b0111, 4'b0101, 1'b1);
      tick();
      rd = 1'b1;
      #1 chk("rd_cycle data_out", 32'(data_out), 32'h5);
      tick();
      rd = 1'b0;
      chk_main("rd_after", 4'b0000, 4'b0111, 4'b0000, 1'b0);

      // collision: bit 2 accepted on the rd_en edge with lat=0001
      raw = 4'b0010;
      repeat (8) tick();
      chk_main("rel02", 4'b0000, 4'b0010, 4'b0000, 1'b0);
      raw = 4'b0011;
      repeat (6) tick();
      chk_main("press0", 4'b0001, 4'b0011, 4'b0001, 1'b1);
      raw = 4'b0111;
      repeat (5) tick();
      chk("coll_pre level", 32'(level), 32'h3);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk_main("collision", 4'b0100, 4'b0111, 4'b0100, 1'b1);
      tick();
      chk_main("coll_after", 4'b0100, 4'b0111, 4'b0000, 1'b1);

      // level mode
      raw_l = 4'b1000;
      repeat (5) tick();
      chk("lvl press+5 data", 32'(data_l), 32'h0);
      tick();
      chk("lvl press+6 data", 32'(data_l), 32'h8);
      chk("lvl press+6 pulse", 32'(pulse_l), 32'h8);
      chk("lvl press+6 pend", 32'(pend_l), 32'h1);
      rd_l = 1'b1;
      tick();
      rd_l = 1'b0;
      chk("lvl rd data", 32'(data_l), 32'h8);
      chk("lvl rd pend", 32'(pend_l), 32'h0);
      chk("lvl rd pulse", 32'(pulse_l), 32'h0);
      tick();
      raw_l = 4'b0000;
      repeat (5) tick();
      chk("lvl rel+5 data", 32'(data_l), 32'h8);
      tick();
      chk("lvl rel+6 data", 32'(data_l), 32'h0);
      chk("lvl rel+6 pulse", 32'(pulse_l), 32'h0);

      // single-sample debounce: latency 3
      raw_d1 = 1'b1;
      repeat (2) tick();
      chk("d1 +2 level", 32'(level_d1), 32'h0);
      tick();
      chk("d1 +3 level", 32'(level_d1), 32'h1);
      chk("d1 +3 pulse", 32'(pulse_d1), 32'h1);
      tick();
      chk("d1 +4 pulse", 32'(pulse_d1), 32'h0);
      chk("d1 +4 data", 32'(data_d1), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
